// File: rtl/load_store_unit_if.sv
// Word-wide data-memory handshake between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: one access per request, lane steering
// for stores, alignment/extension for loads, stall while busy, timeout abort.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    load_store_unit_if.master  dmem,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               store_done,
    output logic               err
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic [7:0]  tmo_cnt;

    logic        req_bad;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        tmo_expired;

    // Misaligned halves/words and encodings with no RV32I meaning are rejected
    // before touching memory; unsigned loads have no store counterpart.
    always_comb begin
        req_bad = 1'b1;
        case (req_funct3)
            F3_B:    req_bad = 1'b0;
            F3_H:    req_bad = req_addr[0];
            F3_W:    req_bad = |req_addr[1:0];
            F3_BU:   req_bad = req_we;
            F3_HU:   req_bad = req_we | req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = req_wdata;
        case (req_funct3)
            F3_B: begin
                st_wstrb = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem.mem_rdata[7:0];
        case (cap_off)
            2'd0: ld_byte = dmem.mem_rdata[7:0];
            2'd1: ld_byte = dmem.mem_rdata[15:8];
            2'd2: ld_byte = dmem.mem_rdata[23:16];
            2'd3: ld_byte = dmem.mem_rdata[31:24];
        endcase
        ld_half = cap_off[1] ? dmem.mem_rdata[31:16] : dmem.mem_rdata[15:0];
        case (cap_funct3)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_ext = {24'h000000, ld_byte};
            F3_HU:   ld_ext = {16'h0000, ld_half};
            default: ld_ext = dmem.mem_rdata;
        endcase
    end

    // The counter spans REQ and WAIT together; it is the budget for the whole access.
    assign tmo_expired = (tmo_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            stall          <= 1'b0;
            dmem.mem_req   <= 1'b0;
            dmem.mem_we    <= 1'b0;
            dmem.mem_addr  <= 32'h0;
            dmem.mem_wstrb <= 4'h0;
            dmem.mem_wdata <= 32'h0;
            load_data      <= 32'h0;
            load_valid     <= 1'b0;
            store_done     <= 1'b0;
            err            <= 1'b0;
            cap_we         <= 1'b0;
            cap_funct3     <= 3'b000;
            cap_off        <= 2'b00;
            tmo_cnt        <= 8'h00;
        end else begin
            load_valid <= 1'b0;
            store_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_off    <= req_addr[1:0];
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            state          <= REQ;
                            req_ready      <= 1'b0;
                            stall          <= 1'b1;
                            tmo_cnt        <= 8'h00;
                            dmem.mem_req   <= 1'b1;
                            dmem.mem_we    <= req_we;
                            dmem.mem_addr  <= {req_addr[31:2], 2'b00};
                            dmem.mem_wstrb <= req_we ? st_wstrb : 4'b0000;
                            dmem.mem_wdata <= req_we ? st_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (dmem.mem_gnt) begin
                        dmem.mem_req <= 1'b0;
                        if (cap_we) begin
                            state      <= DONE;
                            store_done <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tmo_expired) begin
                        state        <= IDLE;
                        dmem.mem_req <= 1'b0;
                        req_ready    <= 1'b1;
                        stall        <= 1'b0;
                        err          <= 1'b1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (dmem.mem_rvalid) begin
                        state      <= DONE;
                        load_data  <= ld_ext;
                        load_valid <= 1'b1;
                    end else if (tmo_expired) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                        err       <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    localparam int TMO = 6;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_ld = 32'h0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .dmem       (mem_bus),
        .load_data  (load_data),
        .load_valid (load_valid),
        .store_done (store_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic bit model_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return a[0] == 1'b0;
            3'b010:  return a[1:0] == 2'b00;
            3'b100:  return !we;
            3'b101:  return !we && a[0] == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] word);
        bit [31:0] sh;
        sh = word >> (8 * off);
        case (f3)
            3'b000:  return 32'(int'(byte'(sh[7:0])));
            3'b001:  return 32'(int'(shortint'(sh[15:0])));
            3'b100:  return sh & 32'h0000_00FF;
            3'b101:  return sh & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic bit [3:0] model_strb(input bit [2:0] f3, input bit [1:0] off);
        case (f3)
            3'b000:  return 4'(1 << off);
            3'b001:  return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit [31:0] model_wdata(input bit [2:0] f3, input bit [31:0] wd);
        case (f3)
            3'b000:  return wd[7:0] * 32'h0101_0101;
            3'b001:  return wd[15:0] * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One full access from the IDLE cycle; gnt_dly/rv_dly of -1 mean never.
    task automatic applyStimulus(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                 input bit [31:0] wdata, input int gnt_dly, input int rv_dly,
                                 input bit [31:0] rdata);
        bit legal;
        bit granted;
        bit done;
        int c;
        legal = model_legal(we, f3, addr);
        checkOutput("ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!legal) begin
            checkOutput("bad_err", err, 1'b1);
            checkOutput("bad_no_req", mem_bus.mem_req, 1'b0);
            checkOutput("bad_ready", req_ready, 1'b1);
            checkOutput("bad_stall", stall, 1'b0);
            checkOutput("bad_ld_hold", load_data, model_ld);
            @(posedge clk); #1;
            checkOutput("bad_err_once", err, 1'b0);
            return;
        end
        granted = 1'b0;
        done    = 1'b0;
        c       = 1;
        while (!done && c <= TMO) begin
            checkOutput("busy_stall", stall, 1'b1);
            checkOutput("busy_ready", req_ready, 1'b0);
            checkOutput("busy_no_lv", load_valid, 1'b0);
            checkOutput("busy_no_err", err, 1'b0);
            if (!granted) begin
                checkOutput("mem_req", mem_bus.mem_req, 1'b1);
                checkOutput("mem_we", mem_bus.mem_we, we);
                checkOutput("mem_addr", mem_bus.mem_addr, addr & ~32'h3);
                if (we) begin
                    checkOutput("mem_wstrb", mem_bus.mem_wstrb, model_strb(f3, addr[1:0]));
                    checkOutput("mem_wdata", mem_bus.mem_wdata, model_wdata(f3, wdata));
                end
                if (gnt_dly >= 0 && c == gnt_dly + 1) begin
                    mem_bus.mem_gnt = 1'b1;
                    granted = 1'b1;
                    if (we) done = 1'b1;
                end
            end else begin
                checkOutput("wait_no_req", mem_bus.mem_req, 1'b0);
                if (rv_dly >= 0 && c == gnt_dly + 1 + rv_dly) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = rdata;
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            mem_bus.mem_gnt    = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = $urandom;
            c++;
        end
        if (done) begin
            checkOutput("done_stall", stall, 1'b1);
            checkOutput("done_err", err, 1'b0);
            checkOutput("store_done", store_done, we);
            checkOutput("load_valid", load_valid, !we);
            if (!we) model_ld = model_load(f3, addr[1:0], rdata);
            checkOutput("load_data", load_data, model_ld);
            @(posedge clk); #1;
            checkOutput("after_sd", store_done, 1'b0);
            checkOutput("after_lv", load_valid, 1'b0);
            checkOutput("after_ready", req_ready, 1'b1);
            checkOutput("after_stall", stall, 1'b0);
        end else begin
            checkOutput("tmo_err", err, 1'b1);
            checkOutput("tmo_no_lv", load_valid, 1'b0);
            checkOutput("tmo_no_sd", store_done, 1'b0);
            checkOutput("tmo_no_req", mem_bus.mem_req, 1'b0);
            checkOutput("tmo_ready", req_ready, 1'b1);
            checkOutput("tmo_stall", stall, 1'b0);
            checkOutput("tmo_ld_hold", load_data, model_ld);
            @(posedge clk); #1;
            checkOutput("tmo_err_once", err, 1'b0);
        end
    endtask

    initial begin
        bit [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst_n              = 1'b0;
        req_valid          = 1'b0;
        req_we             = 1'b0;
        req_funct3         = 3'b000;
        req_addr           = 32'h0;
        req_wdata          = 32'h0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        #12;
        checkOutput("rst_ready", req_ready, 1'b1);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_mem_req", mem_bus.mem_req, 1'b0);
        checkOutput("rst_lv", load_valid, 1'b0);
        checkOutput("rst_sd", store_done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_ld", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 1, 32'h8011_2233);
        applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 1, 32'h8011_2233);
        applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 1, 32'h8011_2233);
        applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 1, 32'h8011_2233);
        applyStimulus(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 0, 1, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 0, 1, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 1, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0404, 32'h0, 3, 1, 32'h1357_9BDF);
        applyStimulus(1'b0, 3'b010, 32'h0000_0408, 32'h0, 1, -1, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h0000_040C, 32'hCAFE_F00D, -1, 1, 32'h0);

        // Reset while a load sits in WAIT, then a late rvalid must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        checkOutput("rst_wait_pre_stall", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wait_req", mem_bus.mem_req, 1'b0);
        checkOutput("rst_wait_stall", stall, 1'b0);
        checkOutput("rst_wait_ready", req_ready, 1'b1);
        model_ld = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h7777_7777;
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        checkOutput("rst_wait_no_lv", load_valid, 1'b0);
        checkOutput("rst_wait_idle", req_ready, 1'b1);
        checkOutput("rst_wait_ld", load_data, model_ld);

        // Reset during REQ must drop mem_req without waiting for a clock.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rst_req_pre", mem_bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", mem_bus.mem_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_req_no_sd", store_done, 1'b0);

        for (int n = 0; n < 60; n++) begin
            bit        we;
            bit [2:0]  f3;
            int        gd;
            int        rd;
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 7)];
            gd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
            rd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 3));
            applyStimulus(we, f3, 32'h0000_1000 + $urandom_range(0, 255), $urandom, gd, rd, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                checkOutput("gap_idle", req_ready, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit of the RV32I pipeline.
- Takes one load or store per request from the execute stage and drives the word-wide data-memory handshake.
- Aligns and extends load data, then presents it as the load-data input of the writeback 4:1 result mux (sel_port = 2'd1 selects it).
- Raises stall to the pipeline while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access is aborted with an error; range 1..255.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents an access
- req_ready  output  1  unit can accept (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bytes significant)
- stall  output  1  high whenever state is not IDLE
- mem_req  output  1  memory request, held until granted
- mem_we  output  1  memory write enable
- mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wstrb  output  4  byte strobes
- mem_wdata  output  32  store data replicated into lanes
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word
- load_data  output  32  aligned/extended load result to writeback mux
- load_valid  output  1  one-cycle pulse, load_data updated
- store_done  output  1  one-cycle pulse, store committed
- err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; timeout counter 0; captured request cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accept on req_valid&&req_ready; capture req_we, funct3, addr, wdata.
  - Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 (011, 110, 111; 100/101 with we=1): no memory access, err pulses the next cycle, stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, with mem_we/addr/wstrb/wdata stable while waiting.
  - On mem_gnt: store -> DONE; load -> WAIT.
- WAIT: on mem_rvalid, capture mem_rdata -> DONE. mem_rvalid in the same cycle as mem_gnt is not possible (memory returns data ≥1 cycle after grant).
- DONE: load_valid (load) or store_done (store) is 1 for exactly this cycle -> IDLE.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES: drop mem_req, err=1 for one cycle (no load_valid), go to IDLE.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], byte replicated ×4.
  - SH: wstrb = 0011 or 1100 by addr[1], half replicated ×2.
  - SW: wstrb = 1111.
- Load extraction: byte lane addr[1:0] or half lane addr[1]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- load_data is registered and holds its value until the next load_valid; stores and errors do not change it.
- Minimum latency with gnt in the first REQ cycle and rvalid the next cycle:
  - Load: accept t0, REQ t1, WAIT t2, load_valid t3.
  - Store: store_done t2.
- req_valid while busy is ignored (req_ready=0); the pipeline holds the request under stall.
- Reset asserted mid-access: immediate return to IDLE, mem_req drops asynchronously, no completion pulse.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, gnt t1, rvalid t2 -> load_valid at t3, load_data=0xDEADBEEF, stall high t1..t3.
- LB addr 0x103 with rdata 0x80112233 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011; LHU -> 0x00008011.
- SB addr 0x201 wdata 0x000000AB -> mem_wstrb=0010, mem_wdata=0xABABABAB, mem_addr=0x200, store_done one cycle after gnt; SH addr 0x202 wdata 0x1234 -> wstrb 1100, wdata 0x12341234.
- LW addr 0x102 -> mem_req never asserts, err=1 for one cycle, load_data unchanged, req_ready back to 1.
- gnt withheld 3 cycles -> mem_req and mem_addr stable throughout; with TIMEOUT_CYCLES=4 and rvalid never asserted -> err pulse, no load_valid, IDLE.
- rst_n low while in WAIT -> mem_req=0, stall=0, req_ready=1 immediately; no load_valid after release.
